// File: rtl/simd_mul_arbiter_pkg.sv
// Shared types for the SIMD multiplier arbiter: element/strobe types, op codes,
// the multiplier request bundle and the performance counter width.
package simd_mul_arbiter_pkg;

  localparam int unsigned ELEN = 64;

  typedef logic [ELEN-1:0]   elen_t;
  typedef logic [ELEN/8-1:0] strb_t;

  typedef enum logic [2:0] {
    VMUL,
    VMULH,
    VMULHU,
    VMACC,
    VNMSAC,
    VMADD,
    VNMSUB
  } ara_op_e;

  typedef struct packed {
    ara_op_e op;
    elen_t   a;
    elen_t   b;
    elen_t   c;
    strb_t   mask;
  } mul_req_t;

  localparam int unsigned SimdMulArbPerfW = 32;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simd_mul_arb_tag_fifo.sv
// Order-preserving FIFO of requester IDs for operations in flight in the
// multiplier. Depth need not be a power of two; push and pop may coincide when full.
module simd_mul_arb_tag_fifo #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic [CntW-1:0]  cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_i) wptr <= (wptr == LastPtr) ? '0 : wptr + PtrW'(1);
      if (pop_i)  rptr <= (rptr == LastPtr) ? '0 : rptr + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr] <= data_i;
  end

  assign data_o  = mem[rptr];
  assign full_o  = (cnt == CntW'(Depth));
  assign empty_o = (cnt == '0);
  assign usage_o = cnt;

endmodule

// File: rtl/simd_mul_arbiter.sv
// Round-robin sharing of one pipelined SIMD multiplier among NumReq requesters,
// with in-order result routing. Optional perf counters: SIMD_MUL_ARB_PERF_EN.
module simd_mul_arbiter
  import simd_mul_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned NumPipeRegs = 0,
  parameter int unsigned MaxInflight = NumPipeRegs + 1,
  parameter int unsigned IdWidth     = id_width(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  mul_req_t [NumReq-1:0] req_i,
  output logic                  mul_valid_o,
  input  logic                  mul_ready_i,
  output mul_req_t              mul_req_o,
  input  logic                  mul_valid_i,
  output logic                  mul_ready_o,
  input  elen_t                 mul_result_i,
  input  strb_t                 mul_mask_i,
  output logic [NumReq-1:0]     res_valid_o,
  input  logic [NumReq-1:0]     res_ready_i,
  output elen_t                 res_result_o,
  output strb_t                 res_mask_o
`ifdef SIMD_MUL_ARB_PERF_EN
  ,
  output logic [NumReq-1:0][SimdMulArbPerfW-1:0] perf_grant_cnt_o,
  output logic [SimdMulArbPerfW-1:0]             perf_stall_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(MaxInflight + 1);
  localparam logic [IdWidth-1:0] LastId = IdWidth'(NumReq - 1);

  logic [IdWidth-1:0] rr_ptr, lock_idx, rr_idx, grant_idx, head;
  logic               lock, rr_found, grant_vld, issue_hs;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]    fifo_usage;

  // Scan from rr_ptr upwards; descending loop so the closest index wins.
  always_comb begin
    logic [IdWidth-1:0] idx;
    rr_idx   = rr_ptr;
    rr_found = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = IdWidth'((int'(rr_ptr) + i) % NumReq);
      if (req_valid_i[idx]) begin
        rr_found = 1'b1;
        rr_idx   = idx;
      end
    end
  end

  assign grant_idx   = lock ? lock_idx : rr_idx;
  assign grant_vld   = !rst_i && (lock ? req_valid_i[lock_idx] : rr_found) &&
                       (!fifo_full || fifo_pop);
  assign issue_hs    = grant_vld && mul_ready_i;
  assign mul_valid_o = grant_vld;
  assign mul_req_o   = grant_vld ? req_i[grant_idx] : '0;

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) req_ready_o[grant_idx] = mul_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (issue_hs) begin
      rr_ptr <= (grant_idx == LastId) ? '0 : grant_idx + IdWidth'(1);
      lock   <= 1'b0;
    end else if (grant_vld) begin
      lock     <= 1'b1;
      lock_idx <= grant_idx;
    end
  end

  simd_mul_arb_tag_fifo #(
    .Depth (MaxInflight),
    .Width (IdWidth),
    .CntW  (CntW)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue_hs),
    .pop_i   (fifo_pop),
    .data_i  (grant_idx),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  // A stalled head requester blocks every return, keeping results in issue order.
  assign mul_ready_o = !rst_i && !fifo_empty && res_ready_i[head];
  assign fifo_pop    = mul_valid_i && mul_ready_o;

  always_comb begin
    res_valid_o = '0;
    if (!rst_i && !fifo_empty) res_valid_o[head] = mul_valid_i;
  end

  assign res_result_o = rst_i ? '0 : mul_result_i;
  assign res_mask_o   = rst_i ? '0 : mul_mask_i;

`ifdef SIMD_MUL_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      for (int r = 0; r < NumReq; r++) begin
        if (issue_hs && grant_idx == IdWidth'(r) && perf_grant_cnt_o[r] != '1)
          perf_grant_cnt_o[r] <= perf_grant_cnt_o[r] + SimdMulArbPerfW'(1);
      end
      if (|req_valid_i && !issue_hs && perf_stall_cnt_o != '1)
        perf_stall_cnt_o <= perf_stall_cnt_o + SimdMulArbPerfW'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_orphan_result : assert property (@(posedge clk_i) disable iff (rst_i)
    !(mul_valid_i && fifo_empty));
  a_usage_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_usage <= CntW'(MaxInflight));
`endif

endmodule

// File: tb/tb_simd_mul_arbiter.sv
// Directed bench for simd_mul_arbiter (NumReq=2, NumPipeRegs=2, three tags in flight);
// the bench plays the multiplier and drives its return path cycle by cycle.
module tb_simd_mul_arbiter;
  import simd_mul_arbiter_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, res_valid, res_ready;
  mul_req_t [1:0] req;
  logic           mvalid_o, mready_i, mvalid_i, mready_o;
  mul_req_t       mreq;
  elen_t          mresult, res_result;
  strb_t          mmask, res_mask;
`ifdef SIMD_MUL_ARB_PERF_EN
  logic [1:0][SimdMulArbPerfW-1:0] perf_grant;
  logic [SimdMulArbPerfW-1:0]      perf_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simd_mul_arbiter #(
    .NumReq      (2),
    .NumPipeRegs (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_i        (req),
    .mul_valid_o  (mvalid_o),
    .mul_ready_i  (mready_i),
    .mul_req_o    (mreq),
    .mul_valid_i  (mvalid_i),
    .mul_ready_o  (mready_o),
    .mul_result_i (mresult),
    .mul_mask_i   (mmask),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_result_o (res_result),
    .res_mask_o   (res_mask)
`ifdef SIMD_MUL_ARB_PERF_EN
    ,
    .perf_grant_cnt_o (perf_grant),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic mr, input logic mv,
                       input logic [63:0] res, input logic [1:0] rr);
    req_valid = v;
    mready_i  = mr;
    mvalid_i  = mv;
    mresult   = res;
    res_ready = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req[0].op = VMUL; req[0].a = 64'd3; req[0].b = 64'd5; req[0].c = '0; req[0].mask = 8'hFF;
    req[1].op = VMUL; req[1].a = 64'd7; req[1].b = 64'd2; req[1].c = '0; req[1].mask = 8'h0F;
    mmask = 8'hA5;

    // Reset: outputs quiet even with both requesters valid.
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("rst_mul_valid", 64'(mvalid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_req_nz", 64'(mreq != '0), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mul_ready", 64'(mready_o), 64'd0);
    tick();
    rst = 1'b0;

    // Fairness: grants alternate 0,1,0,1; results come back in issue order.
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("fair0_valid", 64'(mvalid_o), 64'd1);
    chk("fair0_ready", 64'(req_ready), 64'b01);
    chk("fair0_a", mreq.a, 64'd3);
    tick();
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("fair1_ready", 64'(req_ready), 64'b10);
    chk("fair1_a", mreq.a, 64'd7);
    chk("fair1_b", mreq.b, 64'd2);
    tick();
    drive(2'b11, 1'b1, 1'b1, 64'd15, 2'b11);
    chk("fair2_ready", 64'(req_ready), 64'b01);
    chk("fair2_res_valid", 64'(res_valid), 64'b01);
    chk("fair2_result", res_result, 64'd15);
    chk("fair2_mul_ready", 64'(mready_o), 64'd1);
    tick();
    drive(2'b11, 1'b1, 1'b1, 64'd14, 2'b11);
    chk("fair3_ready", 64'(req_ready), 64'b10);
    chk("fair3_res_valid", 64'(res_valid), 64'b10);
    chk("fair3_result", res_result, 64'd14);
    tick();
    drive(2'b00, 1'b1, 1'b1, 64'd15, 2'b11);
    chk("fair4_mul_valid", 64'(mvalid_o), 64'd0);
    chk("fair4_res_valid", 64'(res_valid), 64'b01);
    tick();
    drive(2'b00, 1'b1, 1'b1, 64'd14, 2'b11);
    chk("fair5_res_valid", 64'(res_valid), 64'b10);
    tick();
    drive(2'b00, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("empty_mul_ready", 64'(mready_o), 64'd0);

    // Lone req0 issue moves rr_ptr to 1 so a lock is observable.
    drive(2'b01, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("pre_ready", 64'(req_ready), 64'b01);
    tick();

    // Stall lock: req0 stays granted although rr_ptr favours req1.
    drive(2'b01, 1'b0, 1'b0, 64'd0, 2'b11);
    chk("stall0_valid", 64'(mvalid_o), 64'd1);
    chk("stall0_ready", 64'(req_ready), 64'b00);
    chk("stall0_a", mreq.a, 64'd3);
    tick();
    for (int c = 1; c <= 2; c++) begin
      drive(2'b11, 1'b0, 1'b0, 64'd0, 2'b11);
      chk($sformatf("stall%0d_a", c), mreq.a, 64'd3);
      chk($sformatf("stall%0d_ready", c), 64'(req_ready), 64'b00);
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("stall3_hs_ready", 64'(req_ready), 64'b01);
    chk("stall3_a", mreq.a, 64'd3);
    tick();
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("stall4_ready", 64'(req_ready), 64'b10);
    chk("stall4_a", mreq.a, 64'd7);
    tick();

    // Full FIFO (tags 0,0,1): issue blocked until the head can pop.
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("full0_mul_valid", 64'(mvalid_o), 64'd0);
    chk("full0_ready", 64'(req_ready), 64'b00);
    tick();
    drive(2'b11, 1'b1, 1'b1, 64'd15, 2'b10);
    chk("full1_res_valid", 64'(res_valid), 64'b01);
    chk("full1_mul_ready", 64'(mready_o), 64'd0);
    chk("full1_mul_valid", 64'(mvalid_o), 64'd0);
    tick();
    drive(2'b11, 1'b1, 1'b1, 64'd15, 2'b11);
    chk("full2_mul_ready", 64'(mready_o), 64'd1);
    chk("full2_mul_valid", 64'(mvalid_o), 64'd1);
    chk("full2_ready", 64'(req_ready), 64'b01);
    tick();

    // Ordering: tags 1,0 wait behind a stalled req0 head.
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 1'b1, 1'b1, 64'd15, 2'b10);
      chk($sformatf("ord%0d_res_valid", c), 64'(res_valid), 64'b01);
      chk($sformatf("ord%0d_mul_ready", c), 64'(mready_o), 64'd0);
      tick();
    end
    drive(2'b00, 1'b1, 1'b1, 64'd15, 2'b11);
    chk("ord2_res_valid", 64'(res_valid), 64'b01);
    chk("ord2_result", res_result, 64'd15);
    tick();
    drive(2'b00, 1'b1, 1'b1, 64'd14, 2'b11);
    chk("ord3_res_valid", 64'(res_valid), 64'b10);
    chk("ord3_result", res_result, 64'd14);
    chk("ord3_mask", 64'(res_mask), 64'hA5);
    tick();
    drive(2'b00, 1'b1, 1'b1, 64'd15, 2'b11);
    chk("ord4_res_valid", 64'(res_valid), 64'b01);
    tick();

    // Reset mid-flight with two tags (1,0) outstanding.
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("mid0_ready", 64'(req_ready), 64'b10);
    tick();
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("mid1_ready", 64'(req_ready), 64'b01);
    tick();
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 64'd14, 2'b11);
    chk("midrst_mul_valid", 64'(mvalid_o), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_mul_ready", 64'(mready_o), 64'd0);
    chk("midrst_result", res_result, 64'd0);
    chk("midrst_mul_req_nz", 64'(mreq != '0), 64'd0);
    tick();
    rst = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("post_ready", 64'(req_ready), 64'b01);
    chk("post_mul_ready", 64'(mready_o), 64'd0);
    tick();
    drive(2'b00, 1'b1, 1'b1, 64'd15, 2'b11);
    chk("post_res_valid", 64'(res_valid), 64'b01);
    tick();
    drive(2'b00, 1'b1, 1'b0, 64'd0, 2'b11);
    chk("post_empty", 64'(mready_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
